param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width; register count NREG = 2**ADDR_W.
REQ-003 SHALL have parameter PC_REG, default 6, index of the program-counter register.
REQ-004 SHALL have parameter ZERO_R0, default 1, where 1 makes register 0 hard-wired to zero.
REQ-005 SHALL have port clk, input, 1, the single clock; all state SHALL update on the rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port rd_a_num, input, ADDR_W, read port A register index.
REQ-008 SHALL have port rd_b_num, input, ADDR_W, read port B register index.
REQ-009 SHALL have port rd_a_out, output, DATA_W, registered read data A.
REQ-010 SHALL have port rd_b_out, output, DATA_W, registered read data B.
REQ-011 SHALL have port wr_num, input, ADDR_W, write register index.
REQ-012 SHALL have port wr_data, input, DATA_W, write data.
REQ-013 SHALL have port wr_en, input, 1, write strobe.
REQ-014 SHALL have port flag_en, input, 1, which enables a condition-flag update from wr_data.
REQ-015 SHALL have port pc_inc, input, 1, which increments the PC register by 1.
REQ-016 SHALL have port pc_out, output, DATA_W, registered PC register value.
REQ-017 SHALL have port cond_out, output, 3, condition flags {zero, positive, negative}.

Function
REQ-018 Reads SHALL proceed every cycle regardless of wr_en, with 1-cycle latency: rd_x_out(n+1) = reg[rd_x_num(n)].
REQ-019 Write bypass: if wr_en=1 and wr_num == rd_x_num in cycle n, rd_x_out(n+1) SHALL equal wr_data(n), not the old contents.
REQ-020 With ZERO_R0=1: writes to index 0 SHALL be discarded, reads of index 0 SHALL return 0, and index 0 SHALL NOT be bypassed.
REQ-021 With ZERO_R0=0: register 0 SHALL behave as an ordinary register.
REQ-022 PC update priority: wr_en with wr_num==PC_REG SHALL win over pc_inc; pc_inc alone SHALL load reg[PC_REG]+1, modulo 2**DATA_W, so all-ones wraps to 0.
REQ-023 pc_out(n+1) SHALL equal the value reg[PC_REG] takes at edge n, with no extra cycle of lag after a write or an increment.
REQ-024 Reads of PC_REG in the same cycle as pc_inc SHALL return the incremented value, using the same bypass rule as REQ-019.
REQ-025 When wr_en=1 and flag_en=1, the flags SHALL load: zero = (wr_data==0), negative = wr_data[DATA_W-1], positive = !zero && !negative; cond_out SHALL show them 1 cycle later.
REQ-026 flag_en SHALL be honoured even for a write to index 0 under ZERO_R0=1; the flags SHALL be computed from wr_data.
REQ-027 flag_en=1 with wr_en=0 SHALL leave the flags unchanged.
REQ-028 An out-of-range PC_REG (>= NREG, or 0 with ZERO_R0=1) SHALL be a parameter error flagged at elaboration.

Reset
REQ-029 While rst=1: all registers, rd_a_out, rd_b_out and pc_out SHALL be 0 and cond_out SHALL be 3'b100, immediately and without waiting for clk.
REQ-030 Writes and pc_inc SHALL be ignored while rst=1; the first edge with rst=0 SHALL behave normally.
REQ-031 Reset asserted mid-operation SHALL discard any write in flight at that edge.

Verification
REQ-032 Reset then read all indices -> every rd_x_out 0, cond_out 3'b100, pc_out 0.
REQ-033 wr_en=1, wr_num=3, wr_data=16'h1234, rd_a_num=3 in the same cycle -> rd_a_out=16'h1234 next cycle; following cycle still 16'h1234.
REQ-034 ZERO_R0=1, write 16'hFFFF to index 0 with flag_en=1 -> read of index 0 returns 0, cond_out=3'b001.
REQ-035 reg[6]=16'hFFFF, pc_inc=1 -> pc_out=0; pc_inc together with a write of 16'h0040 to index 6 -> pc_out=16'h0040.
REQ-036 Write 16'h0005 with flag_en=1, then 16'h8000 with flag_en=0 -> cond_out=3'b010 after both writes.
REQ-037 DATA_W=32, ADDR_W=4: write 32'hDEADBEEF to index 15, read both ports at index 15 -> both return 32'hDEADBEEF; rst pulse mid-stream -> outputs 0 asynchronously.

Source files
------------

// File: rtl/param_register_file.sv
// Parameterised register file with a program counter, condition flags and write bypass.
// Ports: clk, rst (async, active-high); read ports A/B with registered data; write port
// (wr_num, wr_data, wr_en); flag_en; pc_inc; pc_out; cond_out = {zero, positive, negative}.
module param_register_file #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int PC_REG  = 6,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_a_num,
  input  logic [ADDR_W-1:0] rd_b_num,
  output logic [DATA_W-1:0] rd_a_out,
  output logic [DATA_W-1:0] rd_b_out,
  input  logic [ADDR_W-1:0] wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              flag_en,
  input  logic              pc_inc,
  output logic [DATA_W-1:0] pc_out,
  output logic [2:0]        cond_out
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_REG);
  localparam bit HAS_ZERO = (ZERO_R0 != 0);

  // The PC must name a real, writable register.
  generate
    if (PC_REG < 0 || PC_REG >= NREG || (HAS_ZERO && PC_REG == 0)) begin : g_bad_pc
      $error("param_register_file: PC_REG out of range");
    end
  endgenerate

  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_rd_a;
  logic [DATA_W-1:0] r_rd_b;
  logic [DATA_W-1:0] r_pc;
  logic [2:0]        r_cond;

  logic [DATA_W-1:0] w_next [NREG];
  logic [DATA_W-1:0] w_pc_inc_val;
  logic              w_wr_ok;
  logic              w_zero;
  logic              w_neg;
  logic              w_pos;
  logic [2:0]        w_flags;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // Writes to a hard-wired zero register are dropped.
  assign w_wr_ok = wr_en && !(HAS_ZERO && wr_num == '0);

  assign w_pc_inc_val = r_regs[PC_IDX] + DATA_W'(1);

  // Next-state view of every register. Reads sample this, which gives
  // write bypass and PC-increment bypass with one mechanism. The explicit
  // write is applied last so it wins over pc_inc.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_next[i] = r_regs[i];
    end
    if (pc_inc) begin
      w_next[PC_IDX] = w_pc_inc_val;
    end
    if (w_wr_ok) begin
      w_next[wr_num] = wr_data;
    end
    if (HAS_ZERO) begin
      w_next[0] = '0;
    end
  end

  always_comb begin
    w_rd_a = w_next[rd_a_num];
    w_rd_b = w_next[rd_b_num];
    if (HAS_ZERO && rd_a_num == '0) begin
      w_rd_a = '0;
    end
    if (HAS_ZERO && rd_b_num == '0) begin
      w_rd_b = '0;
    end
  end

  // Flags come from wr_data even when the register write itself is dropped.
  assign w_zero  = (wr_data == '0);
  assign w_neg   = wr_data[DATA_W-1];
  assign w_pos   = !w_zero && !w_neg;
  assign w_flags = {w_zero, w_pos, w_neg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_rd_a <= '0;
      r_rd_b <= '0;
      r_pc   <= '0;
      r_cond <= 3'b100;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= w_next[i];
      end
      r_rd_a <= w_rd_a;
      r_rd_b <= w_rd_b;
      r_pc   <= w_next[PC_IDX];
      if (wr_en && flag_en) begin
        r_cond <= w_flags;
      end
    end
  end

  assign rd_a_out = r_rd_a;
  assign rd_b_out = r_rd_b;
  assign pc_out   = r_pc;
  assign cond_out = r_cond;

endmodule

// File: tb/tb_param_register_file.sv
// Directed self-checking bench for param_register_file.
// Covers the default 16-bit build and a 32-bit/16-entry build with ordinary r0.
module tb_param_register_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  rd_a_num, rd_b_num, wr_num;
  logic [15:0] wr_data;
  logic        wr_en, flag_en, pc_inc;
  logic [15:0] rd_a_out, rd_b_out, pc_out;
  logic [2:0]  cond_out;

  logic [3:0]  w_rd_a_num, w_rd_b_num, w_wr_num;
  logic [31:0] w_wr_data;
  logic        w_wr_en, w_flag_en, w_pc_inc;
  logic [31:0] w_rd_a_out, w_rd_b_out, w_pc_out;
  logic [2:0]  w_cond_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_register_file dut (
    .clk(clk), .rst(rst),
    .rd_a_num(rd_a_num), .rd_b_num(rd_b_num),
    .rd_a_out(rd_a_out), .rd_b_out(rd_b_out),
    .wr_num(wr_num), .wr_data(wr_data), .wr_en(wr_en),
    .flag_en(flag_en), .pc_inc(pc_inc),
    .pc_out(pc_out), .cond_out(cond_out)
  );

  param_register_file #(.DATA_W(32), .ADDR_W(4), .PC_REG(6), .ZERO_R0(0)) dut32 (
    .clk(clk), .rst(rst),
    .rd_a_num(w_rd_a_num), .rd_b_num(w_rd_b_num),
    .rd_a_out(w_rd_a_out), .rd_b_out(w_rd_b_out),
    .wr_num(w_wr_num), .wr_data(w_wr_data), .wr_en(w_wr_en),
    .flag_en(w_flag_en), .pc_inc(w_pc_inc),
    .pc_out(w_pc_out), .cond_out(w_cond_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_a_num = 0; rd_b_num = 0; wr_num = 0; wr_data = 0;
    wr_en = 0; flag_en = 0; pc_inc = 0;
    w_rd_a_num = 0; w_rd_b_num = 0; w_wr_num = 0; w_wr_data = 0;
    w_wr_en = 0; w_flag_en = 0; w_pc_inc = 0;
  endtask

  task automatic test_reset();
    idle();
    wr_en = 1; wr_num = 3; wr_data = 16'h7777; pc_inc = 1;
    tick();
    checks++;
    if (rd_a_out !== 16'h0 || pc_out !== 16'h0 || cond_out !== 3'b100) begin
      failures++;
      $display("FAIL reset_hold a=%h pc=%h cond=%b exp 0 0 100", rd_a_out, pc_out, cond_out);
    end
    idle();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      rd_a_num = 3'(i); rd_b_num = 3'(7 - i);
      tick();
      checks++;
      if (rd_a_out !== 16'h0 || rd_b_out !== 16'h0) begin
        failures++;
        $display("FAIL reset_read idx=%0d a=%h b=%h exp 0", i, rd_a_out, rd_b_out);
      end
    end
    checks++;
    if (cond_out !== 3'b100 || pc_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_state cond=%b pc=%h exp 100 0", cond_out, pc_out);
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1; wr_num = 3; wr_data = 16'h1234; rd_a_num = 3; rd_b_num = 2;
    tick();
    checks++;
    if (rd_a_out !== 16'h1234) begin
      failures++;
      $display("FAIL bypass_a got %h exp 1234", rd_a_out);
    end
    checks++;
    if (rd_b_out !== 16'h0) begin
      failures++;
      $display("FAIL bypass_b_other got %h exp 0", rd_b_out);
    end
    wr_en = 0; rd_b_num = 3;
    tick();
    checks++;
    if (rd_a_out !== 16'h1234 || rd_b_out !== 16'h1234) begin
      failures++;
      $display("FAIL hold_read a=%h b=%h exp 1234", rd_a_out, rd_b_out);
    end
    wr_en = 1; wr_num = 5; wr_data = 16'hA5A5; rd_a_num = 5; rd_b_num = 3;
    tick();
    wr_en = 1; wr_num = 5; wr_data = 16'h0F0F; rd_a_num = 5;
    tick();
    checks++;
    if (rd_a_out !== 16'h0F0F || rd_b_out !== 16'h1234) begin
      failures++;
      $display("FAIL back_to_back a=%h b=%h exp 0f0f 1234", rd_a_out, rd_b_out);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    wr_en = 1; flag_en = 1; wr_num = 0; wr_data = 16'hFFFF; rd_a_num = 0;
    tick();
    checks++;
    if (rd_a_out !== 16'h0) begin
      failures++;
      $display("FAIL r0_bypass got %h exp 0", rd_a_out);
    end
    checks++;
    if (cond_out !== 3'b001) begin
      failures++;
      $display("FAIL r0_flags got %b exp 001", cond_out);
    end
    idle();
    tick();
    checks++;
    if (rd_a_out !== 16'h0) begin
      failures++;
      $display("FAIL r0_read got %h exp 0", rd_a_out);
    end
  endtask

  task automatic test_pc();
    idle();
    wr_en = 1; wr_num = 6; wr_data = 16'hFFFF;
    tick();
    checks++;
    if (pc_out !== 16'hFFFF) begin
      failures++;
      $display("FAIL pc_write got %h exp ffff", pc_out);
    end
    idle();
    pc_inc = 1; rd_b_num = 6;
    tick();
    checks++;
    if (pc_out !== 16'h0 || rd_b_out !== 16'h0) begin
      failures++;
      $display("FAIL pc_wrap pc=%h b=%h exp 0 0", pc_out, rd_b_out);
    end
    wr_en = 1; wr_num = 6; wr_data = 16'h0040;
    tick();
    checks++;
    if (pc_out !== 16'h0040 || rd_b_out !== 16'h0040) begin
      failures++;
      $display("FAIL pc_write_wins pc=%h b=%h exp 0040", pc_out, rd_b_out);
    end
    wr_en = 0;
    tick();
    checks++;
    if (pc_out !== 16'h0041 || rd_b_out !== 16'h0041) begin
      failures++;
      $display("FAIL pc_inc pc=%h b=%h exp 0041", pc_out, rd_b_out);
    end
    idle();
    rd_a_num = 6;
    tick();
    checks++;
    if (pc_out !== 16'h0041 || rd_a_out !== 16'h0041) begin
      failures++;
      $display("FAIL pc_hold pc=%h a=%h exp 0041", pc_out, rd_a_out);
    end
  endtask

  task automatic test_flags();
    idle();
    wr_en = 1; flag_en = 1; wr_num = 1; wr_data = 16'h0005;
    tick();
    checks++;
    if (cond_out !== 3'b010) begin
      failures++;
      $display("FAIL flags_pos got %b exp 010", cond_out);
    end
    flag_en = 0; wr_data = 16'h8000;
    tick();
    checks++;
    if (cond_out !== 3'b010) begin
      failures++;
      $display("FAIL flags_no_en got %b exp 010", cond_out);
    end
    wr_en = 0; flag_en = 1; wr_data = 16'h0000;
    tick();
    checks++;
    if (cond_out !== 3'b010) begin
      failures++;
      $display("FAIL flags_no_wr got %b exp 010", cond_out);
    end
    wr_en = 1; wr_num = 2;
    tick();
    checks++;
    if (cond_out !== 3'b100) begin
      failures++;
      $display("FAIL flags_zero got %b exp 100", cond_out);
    end
    wr_data = 16'h8001;
    tick();
    checks++;
    if (cond_out !== 3'b001) begin
      failures++;
      $display("FAIL flags_neg got %b exp 001", cond_out);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    wr_en = 1; wr_num = 4; wr_data = 16'hBEEF; pc_inc = 1;
    #3;
    rst = 1;
    #1;
    checks++;
    if (rd_a_out !== 16'h0 || pc_out !== 16'h0 || cond_out !== 3'b100) begin
      failures++;
      $display("FAIL async_reset a=%h pc=%h cond=%b exp 0 0 100", rd_a_out, pc_out, cond_out);
    end
    tick();
    idle();
    rst = 0;
    rd_a_num = 4; rd_b_num = 6;
    tick();
    checks++;
    if (rd_a_out !== 16'h0 || rd_b_out !== 16'h0 || pc_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_drop_write a=%h b=%h pc=%h exp 0", rd_a_out, rd_b_out, pc_out);
    end
    pc_inc = 1;
    tick();
    checks++;
    if (pc_out !== 16'h0001) begin
      failures++;
      $display("FAIL first_edge_after_reset pc=%h exp 0001", pc_out);
    end
  endtask

  task automatic test_wide();
    idle();
    w_wr_en = 1; w_wr_num = 15; w_wr_data = 32'hDEADBEEF;
    w_rd_a_num = 15; w_rd_b_num = 15;
    tick();
    checks++;
    if (w_rd_a_out !== 32'hDEADBEEF || w_rd_b_out !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wide_bypass a=%h b=%h exp deadbeef", w_rd_a_out, w_rd_b_out);
    end
    w_wr_num = 0; w_wr_data = 32'h0000_0011; w_rd_a_num = 0;
    tick();
    w_wr_en = 0;
    tick();
    checks++;
    if (w_rd_a_out !== 32'h11 || w_rd_b_out !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wide_r0 a=%h b=%h exp 11 deadbeef", w_rd_a_out, w_rd_b_out);
    end
    w_pc_inc = 1;
    tick();
    checks++;
    if (w_pc_out !== 32'h1) begin
      failures++;
      $display("FAIL wide_pc got %h exp 1", w_pc_out);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if (w_rd_a_out !== 32'h0 || w_rd_b_out !== 32'h0 || w_pc_out !== 32'h0) begin
      failures++;
      $display("FAIL wide_async_reset a=%h b=%h pc=%h exp 0", w_rd_a_out, w_rd_b_out, w_pc_out);
    end
    tick();
    idle();
    rst = 0;
    w_rd_a_num = 15; w_rd_b_num = 0;
    tick();
    checks++;
    if (w_rd_a_out !== 32'h0 || w_rd_b_out !== 32'h0 || w_cond_out !== 3'b100) begin
      failures++;
      $display("FAIL wide_after_reset a=%h b=%h cond=%b exp 0 0 100", w_rd_a_out, w_rd_b_out, w_cond_out);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_pc();
    test_flags();
    test_reset_mid();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
